// File: rtl/frame_sequencer_if.sv
// Frame request and timing outputs shared between the sequencer and the
// pixel datapath.
interface frame_sequencer_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int ROW_WIDTH  = 9
);
    logic                  start;
    logic                  vertical_Pulse;
    logic                  horizontal_Pulse;
    logic                  read_Enable;
    logic [ADDR_WIDTH-1:0] pixel_Address;
    logic [ROW_WIDTH-1:0]  row_Index;
    logic                  busy;
    logic                  done_Flag;

    modport master (
        output start,
        input  vertical_Pulse, horizontal_Pulse, read_Enable,
        input  pixel_Address, row_Index, busy, done_Flag
    );

    modport slave (
        input  start,
        output vertical_Pulse, horizontal_Pulse, read_Enable,
        output pixel_Address, row_Index, busy, done_Flag
    );
endinterface

// File: rtl/frame_sequencer.sv
// Frame timing controller: start-up interval, then per row a blanking
// interval followed by a burst of pixel-pair reads, then a done pulse.
// All outputs are registered; strobes are decoded from the next state so
// they line up with the state they describe.
module frame_sequencer #(
    parameter int IMAGE_WIDTH           = 768,
    parameter int IMAGE_HEIGHT          = 512,
    parameter int STARTUP_DELAY         = 100,
    parameter int HORIZONTAL_SYNC_DELAY = 160,
    parameter int ADDR_WIDTH            = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
    parameter int ROW_WIDTH             = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    frame_sequencer_if.slave  bus
);
    localparam int MAX_A = (STARTUP_DELAY > HORIZONTAL_SYNC_DELAY) ? STARTUP_DELAY
                                                                    : HORIZONTAL_SYNC_DELAY;
    localparam int MAX_D = (MAX_A > IMAGE_WIDTH/2) ? MAX_A : IMAGE_WIDTH/2;
    localparam int CNT_W = $clog2(MAX_D + 1);

    localparam logic [CNT_W-1:0]     VS_LAST  = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0]     HS_LAST  = CNT_W'(HORIZONTAL_SYNC_DELAY - 1);
    localparam logic [CNT_W-1:0]     DA_LAST  = CNT_W'(IMAGE_WIDTH/2 - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, DATA, DONE} state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d;
    logic [ROW_WIDTH-1:0]  row, row_d;
    logic                  vp_q, hp_q, busy_q, done_q;

    // State, shared delay counter, address and row registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            row   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            addr  <= addr_d;
            row   <= row_d;
        end
    end

    // Next-state logic; the counter restarts from 0 on every transition.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        addr_d  = addr;
        row_d   = row;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = VSYNC;
                    addr_d  = '0;
                    row_d   = '0;
                end
            end
            VSYNC: begin
                if (cnt == VS_LAST) begin
                    state_d = HSYNC;
                    cnt_d   = '0;
                end
            end
            HSYNC: begin
                if (cnt == HS_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                // Rows are contiguous, so the address simply keeps stepping
                // across the row boundary.
                addr_d = addr + ADDR_WIDTH'(2);
                if (cnt == DA_LAST) begin
                    cnt_d = '0;
                    if (row == ROW_LAST) begin
                        state_d = DONE;
                        addr_d  = '0;
                        row_d   = '0;
                    end else begin
                        state_d = HSYNC;
                        row_d   = row + ROW_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes registered from the next state so they coincide with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vp_q   <= 1'b0;
            hp_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            vp_q   <= (state_d == VSYNC);
            hp_q   <= (state_d == DATA);
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.vertical_Pulse   = vp_q;
    assign bus.horizontal_Pulse = hp_q;
    assign bus.read_Enable      = hp_q;
    assign bus.pixel_Address    = addr;
    assign bus.row_Index        = row;
    assign bus.busy             = busy_q;
    assign bus.done_Flag        = done_q;
endmodule
